// File: rtl/pipe_fetch.sv
// Fetch stage and fetch-to-decode register. Owns the PC and talks to a variable-latency
// instruction memory. Absorbs stalls, wait states and redirects; bubbles are NOP with validd=0.
module pipe_fetch #(
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic                     flush_d,
    input  logic                     pcsrc_e,
    input  logic [ADDRESS_WIDTH-1:0] pctarget_e,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instrd,
    output logic [ADDRESS_WIDTH-1:0] pcd,
    output logic [ADDRESS_WIDTH-1:0] pcplus4d,
    output logic                     validd,
    output logic                     fetch_busy
);

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic                     started_reg;
    logic [ADDRESS_WIDTH-1:0] pcf_reg, pcf_next;
    logic                     redir_pend_reg, redir_pend_next;
    logic [ADDRESS_WIDTH-1:0] target_reg, target_next;
    logic [DATA_WIDTH-1:0]    buf_instr_reg, buf_instr_next;
    logic [ADDRESS_WIDTH-1:0] buf_pc_reg, buf_pc_next;
    logic [DATA_WIDTH-1:0]    instrd_reg, instrd_next;
    logic [ADDRESS_WIDTH-1:0] pcd_reg, pcd_next;
    logic [ADDRESS_WIDTH-1:0] pcplus4d_reg, pcplus4d_next;
    logic                     validd_reg, validd_next;

    logic                     accept;
    logic                     deliver;
    logic [DATA_WIDTH-1:0]    deliver_instr;
    logic [ADDRESS_WIDTH-1:0] deliver_pc;
    logic [ADDRESS_WIDTH-1:0] pcf_plus4;

    // started_reg keeps the request low for the first cycle after reset so a
    // response belonging to an abandoned pre-reset transaction is never accepted.
    assign imem_req   = (state_reg == FETCH) && started_reg;
    assign imem_addr  = pcf_reg;
    assign accept     = imem_req && imem_ready;
    assign fetch_busy = imem_req && !imem_ready;
    assign pcf_plus4  = pcf_reg + ADDRESS_WIDTH'(4);

    assign instrd   = instrd_reg;
    assign pcd      = pcd_reg;
    assign pcplus4d = pcplus4d_reg;
    assign validd   = validd_reg;

    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        redir_pend_next = redir_pend_reg;
        target_next     = target_reg;
        buf_instr_next  = buf_instr_reg;
        buf_pc_next     = buf_pc_reg;
        deliver         = 1'b0;
        deliver_instr   = buf_instr_reg;
        deliver_pc      = buf_pc_reg;
        case (state_reg)
            FETCH: begin
                if (accept) begin
                    if (pcsrc_e) begin
                        pcf_next        = pctarget_e;
                        redir_pend_next = 1'b0;
                    end else if (redir_pend_reg) begin
                        pcf_next        = target_reg;
                        redir_pend_next = 1'b0;
                    end else begin
                        pcf_next = pcf_plus4;
                        if (stall_f) begin
                            buf_instr_next = imem_rdata;
                            buf_pc_next    = pcf_reg;
                            state_next     = HELD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_instr = imem_rdata;
                            deliver_pc    = pcf_reg;
                        end
                    end
                end else if (pcsrc_e) begin
                    // The address must not move under an outstanding request.
                    if (imem_req) begin
                        redir_pend_next = 1'b1;
                        target_next     = pctarget_e;
                    end else begin
                        pcf_next = pctarget_e;
                    end
                end
            end
            HELD: begin
                if (pcsrc_e) begin
                    pcf_next   = pctarget_e;
                    state_next = FETCH;
                end else if (!stall_f) begin
                    deliver    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        instrd_next   = instrd_reg;
        pcd_next      = pcd_reg;
        pcplus4d_next = pcplus4d_reg;
        validd_next   = validd_reg;
        if (flush_d) begin
            instrd_next   = NOP_INSTR;
            pcd_next      = '0;
            pcplus4d_next = '0;
            validd_next   = 1'b0;
        end else if (stall_f) begin
            instrd_next = instrd_reg;
        end else if (deliver) begin
            instrd_next   = deliver_instr;
            pcd_next      = deliver_pc;
            pcplus4d_next = deliver_pc + ADDRESS_WIDTH'(4);
            validd_next   = 1'b1;
        end else begin
            instrd_next = NOP_INSTR;
            validd_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH;
            started_reg    <= 1'b0;
            pcf_reg        <= RESET_PC;
            redir_pend_reg <= 1'b0;
            target_reg     <= '0;
            buf_instr_reg  <= '0;
            buf_pc_reg     <= '0;
            instrd_reg     <= NOP_INSTR;
            pcd_reg        <= '0;
            pcplus4d_reg   <= '0;
            validd_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            started_reg    <= 1'b1;
            pcf_reg        <= pcf_next;
            redir_pend_reg <= redir_pend_next;
            target_reg     <= target_next;
            buf_instr_reg  <= buf_instr_next;
            buf_pc_reg     <= buf_pc_next;
            instrd_reg     <= instrd_next;
            pcd_reg        <= pcd_next;
            pcplus4d_reg   <= pcplus4d_next;
            validd_reg     <= validd_next;
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Self-checking bench for pipe_fetch: directed scenarios plus a randomized run
// scored against an in-order program-counter reference model.
module tb_pipe_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0, flush_d = 1'b0, pcsrc_e = 1'b0;
    logic [31:0] pctarget_e = '0;
    logic        imem_req, imem_ready, fetch_busy, validd;
    logic [31:0] imem_addr, imem_rdata, instrd, pcd, pcplus4d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
        .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d), .validd(validd),
        .fetch_busy(fetch_busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    // Memory model: one address can be given fixed wait states, otherwise zero or random.
    logic [7:0]  wait_cnt = '0;
    logic [7:0]  rand_wait = '0;
    logic [7:0]  slow_wait = '0;
    logic [7:0]  need_w;
    logic [31:0] slow_addr = 32'h1;
    bit          rand_mode = 1'b0;

    always_comb begin
        need_w = rand_mode ? rand_wait : 8'd0;
        if (imem_addr == slow_addr) need_w = slow_wait;
    end
    assign imem_ready = imem_req && (wait_cnt >= need_w);
    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 8'd1;
        else begin
            wait_cnt  <= '0;
            rand_wait <= 8'($urandom_range(0, 3));
        end
    end

    task automatic do_reset;
        rst_n = 1'b0; stall_f = 0; flush_d = 0; pcsrc_e = 0; pctarget_e = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall_f = 0; flush_d = 0; pcsrc_e = 0;
        @(posedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        checks++; if (validd !== 1'b0 || instrd !== NOP) begin errors++; $display("FAIL rst_dec: validd %0b instrd %h want 0 %h", validd, instrd, NOP); end
        checks++; if (pcd !== 32'h0 || pcplus4d !== 32'h0) begin errors++; $display("FAIL rst_pc: pcd %h pcplus4d %h want 0 0", pcd, pcplus4d); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_cycle_req: got %0b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: req %0b addr %h want 1 0", imem_req, imem_addr); end
        // reset in the middle of a wait-stated request
        slow_addr = 32'h4; slow_wait = 8'd3;
        tick();
        checks++; if (fetch_busy !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL mid_busy: busy %0b addr %h want 1 4", fetch_busy, imem_addr); end
        #2 rst_n = 1'b0; #1;
        checks++; if (imem_req !== 1'b0 || validd !== 1'b0 || pcd !== 32'h0) begin errors++; $display("FAIL async_rst: req %0b validd %0b pcd %h want 0 0 0", imem_req, validd, pcd); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %0b want 0", imem_req); end
        slow_addr = 32'h1;
        tick();
        checks++; if (imem_addr !== 32'h0 || validd !== 1'b0) begin errors++; $display("FAIL post_rst_addr: addr %h validd %0b want 0 0", imem_addr, validd); end
        tick();
        checks++; if (validd !== 1'b1 || pcd !== 32'h0) begin errors++; $display("FAIL post_rst_deliver: validd %0b pcd %h want 1 0", validd, pcd); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait;
        do_reset();
        tick();
        checks++; if (imem_addr !== 32'h0 || validd !== 1'b0) begin errors++; $display("FAIL zw_c1: addr %h validd %0b want 0 0", imem_addr, validd); end
        tick();
        checks++; if (imem_addr !== 32'h4 || validd !== 1'b1 || pcd !== 32'h0) begin errors++; $display("FAIL zw_c2: addr %h validd %0b pcd %h want 4 1 0", imem_addr, validd, pcd); end
        checks++; if (instrd !== mem_word(32'h0) || pcplus4d !== 32'h4) begin errors++; $display("FAIL zw_c2_data: instrd %h pcplus4d %h want %h 4", instrd, pcplus4d, mem_word(32'h0)); end
        tick();
        checks++; if (imem_addr !== 32'h8 || pcd !== 32'h4 || instrd !== mem_word(32'h4)) begin errors++; $display("FAIL zw_c3: addr %h pcd %h instrd %h want 8 4 %h", imem_addr, pcd, instrd, mem_word(32'h4)); end
        $display("test_zero_wait done");
    endtask

    task automatic test_wait_states;
        slow_addr = 32'h8; slow_wait = 8'd2;
        do_reset();
        repeat (3) tick();
        checks++; if (imem_addr !== 32'h8 || fetch_busy !== 1'b1 || pcd !== 32'h4) begin errors++; $display("FAIL ws_c3: addr %h busy %0b pcd %h want 8 1 4", imem_addr, fetch_busy, pcd); end
        tick();
        checks++; if (imem_addr !== 32'h8 || fetch_busy !== 1'b1 || validd !== 1'b0) begin errors++; $display("FAIL ws_c4: addr %h busy %0b validd %0b want 8 1 0", imem_addr, fetch_busy, validd); end
        checks++; if (instrd !== NOP) begin errors++; $display("FAIL ws_bubble: instrd %h want %h", instrd, NOP); end
        tick();
        checks++; if (imem_addr !== 32'h8 || fetch_busy !== 1'b0 || validd !== 1'b0) begin errors++; $display("FAIL ws_c5: addr %h busy %0b validd %0b want 8 0 0", imem_addr, fetch_busy, validd); end
        tick();
        checks++; if (validd !== 1'b1 || pcd !== 32'h8 || imem_addr !== 32'hC) begin errors++; $display("FAIL ws_c6: validd %0b pcd %h addr %h want 1 8 c", validd, pcd, imem_addr); end
        slow_addr = 32'h1;
        $display("test_wait_states done");
    endtask

    task automatic test_stall;
        do_reset();
        repeat (4) tick();
        checks++; if (imem_addr !== 32'hC || pcd !== 32'h8) begin errors++; $display("FAIL st_pre: addr %h pcd %h want c 8", imem_addr, pcd); end
        stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || pcd !== 32'h8 || validd !== 1'b1 || instrd !== mem_word(32'h8)) begin
                errors++; $display("FAIL st_hold%0d: req %0b pcd %h validd %0b instrd %h want 0 8 1 %h", i, imem_req, pcd, validd, instrd, mem_word(32'h8)); end
        end
        stall_f = 1'b0;
        tick();
        checks++; if (pcd !== 32'hC || validd !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL st_release: pcd %h validd %0b req %0b addr %h want c 1 1 10", pcd, validd, imem_req, imem_addr); end
        $display("test_stall done");
    endtask

    task automatic test_redirect_pending;
        slow_addr = 32'h20; slow_wait = 8'd2;
        do_reset();
        tick();
        pcsrc_e = 1'b1; pctarget_e = 32'h20;
        tick();
        checks++; if (imem_addr !== 32'h20 || validd !== 1'b0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL rd_c2: addr %h validd %0b busy %0b want 20 0 1", imem_addr, validd, fetch_busy); end
        pctarget_e = 32'h300;
        tick();
        checks++; if (imem_addr !== 32'h20 || validd !== 1'b0) begin errors++; $display("FAIL rd_c3: addr %h validd %0b want 20 0", imem_addr, validd); end
        pctarget_e = 32'h100;
        tick();
        checks++; if (imem_addr !== 32'h20 || validd !== 1'b0) begin errors++; $display("FAIL rd_c4: addr %h validd %0b want 20 0", imem_addr, validd); end
        pcsrc_e = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h100 || validd !== 1'b0) begin errors++; $display("FAIL rd_c5: addr %h validd %0b want 100 0", imem_addr, validd); end
        tick();
        checks++; if (validd !== 1'b1 || pcd !== 32'h100 || instrd !== mem_word(32'h100)) begin errors++; $display("FAIL rd_c6: validd %0b pcd %h instrd %h want 1 100 %h", validd, pcd, instrd, mem_word(32'h100)); end
        slow_addr = 32'h1;
        $display("test_redirect_pending done");
    endtask

    task automatic test_flush_held;
        do_reset();
        tick();
        pcsrc_e = 1'b1; pctarget_e = 32'h3C;
        tick();
        pcsrc_e = 1'b0;
        tick();
        checks++; if (pcd !== 32'h3C || validd !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL fh_pre: pcd %h validd %0b addr %h want 3c 1 40", pcd, validd, imem_addr); end
        stall_f = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || pcd !== 32'h3C || validd !== 1'b1) begin errors++; $display("FAIL fh_held: req %0b pcd %h validd %0b want 0 3c 1", imem_req, pcd, validd); end
        flush_d = 1'b1;
        tick();
        checks++; if (instrd !== NOP || validd !== 1'b0 || pcd !== 32'h0 || pcplus4d !== 32'h0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL fh_flush: instrd %h validd %0b pcd %h pcplus4d %h req %0b want %h 0 0 0 0", instrd, validd, pcd, pcplus4d, imem_req, NOP); end
        flush_d = 1'b0; stall_f = 1'b0;
        tick();
        checks++; if (pcd !== 32'h40 || validd !== 1'b1 || instrd !== mem_word(32'h40) || pcplus4d !== 32'h44 || imem_addr !== 32'h44) begin
            errors++; $display("FAIL fh_release: pcd %h validd %0b instrd %h pcplus4d %h addr %h want 40 1 %h 44 44", pcd, validd, instrd, pcplus4d, imem_addr, mem_word(32'h40)); end
        $display("test_flush_held done");
    endtask

    task automatic test_wrap;
        do_reset();
        tick();
        pcsrc_e = 1'b1; pctarget_e = 32'hFFFF_FFFC;
        tick();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        pcsrc_e = 1'b0;
        tick();
        checks++; if (pcd !== 32'hFFFF_FFFC || pcplus4d !== 32'h0 || imem_addr !== 32'h0 || validd !== 1'b1) begin
            errors++; $display("FAIL wrap: pcd %h pcplus4d %h addr %h validd %0b want fffffffc 0 0 1", pcd, pcplus4d, imem_addr, validd); end
        tick();
        checks++; if (pcd !== 32'h0 || pcplus4d !== 32'h4) begin errors++; $display("FAIL wrap_next: pcd %h pcplus4d %h want 0 4", pcd, pcplus4d); end
        $display("test_wrap done");
    endtask

    // Reference: decode must see the program-order PC stream, restarting at each redirect target.
    task automatic test_random;
        logic [31:0] exp_pc, t, p_instr, p_pcd, p_pc4, prev_addr;
        bit          s, p, f, p_valid, prev_busy;
        int          delivered;
        rand_mode = 1'b1; slow_addr = 32'h1;
        do_reset();
        tick();
        exp_pc = 32'h0; delivered = 0; prev_busy = 1'b0; prev_addr = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 11) == 0);
            f = (s || p) && ($urandom_range(0, 1) == 1);
            t = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            stall_f = s; pcsrc_e = p; flush_d = f; pctarget_e = t;
            p_instr = instrd; p_pcd = pcd; p_pc4 = pcplus4d; p_valid = validd;
            @(negedge clk); #1;
            checks++; if (fetch_busy !== (imem_req && !imem_ready)) begin errors++; $display("FAIL rnd_busy cyc %0d: got %0b want %0b", cyc, fetch_busy, imem_req && !imem_ready); end
            if (prev_busy) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable cyc %0d: req %0b addr %h want 1 %h", cyc, imem_req, imem_addr, prev_addr); end
            end
            prev_busy = imem_req && !imem_ready; prev_addr = imem_addr;
            @(posedge clk); #1;
            if (f) begin
                checks++; if (instrd !== NOP || validd !== 1'b0 || pcd !== 32'h0 || pcplus4d !== 32'h0) begin errors++; $display("FAIL rnd_flush cyc %0d: instrd %h validd %0b pcd %h pcplus4d %h", cyc, instrd, validd, pcd, pcplus4d); end
            end else if (s) begin
                checks++; if (instrd !== p_instr || validd !== p_valid || pcd !== p_pcd || pcplus4d !== p_pc4) begin errors++; $display("FAIL rnd_hold cyc %0d: instrd %h validd %0b pcd %h want %h %0b %h", cyc, instrd, validd, pcd, p_instr, p_valid, p_pcd); end
            end else if (validd === 1'b1) begin
                checks++; if (p || pcd !== exp_pc || instrd !== mem_word(exp_pc) || pcplus4d !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_deliver cyc %0d: pcd %h instrd %h pcplus4d %h redir %0b want pcd %h", cyc, pcd, instrd, pcplus4d, p, exp_pc); end
                exp_pc = exp_pc + 32'd4; delivered++;
            end else begin
                checks++; if (instrd !== NOP || pcd !== p_pcd || pcplus4d !== p_pc4) begin errors++; $display("FAIL rnd_bubble cyc %0d: instrd %h pcd %h want %h %h", cyc, instrd, pcd, NOP, p_pcd); end
            end
            if (p) exp_pc = t;
        end
        stall_f = 0; pcsrc_e = 0; flush_d = 0; rand_mode = 1'b0;
        checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: delivered %0d want >= 200", delivered); end
        $display("test_random done: %0d instructions delivered", delivered);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_flush_held();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
Fetch stage plus fetch-to-decode pipeline register, directly upstream of the decode-to-execute register. It owns the PC and issues requests to a variable-latency instruction memory. It absorbs stalls, wait states and execute-stage redirects, and presents instrd/pcd/pcplus4d/validd to decode. Bubbles are encoded as NOP with validd=0.

Parameters:
DATA_WIDTH, 32, instruction/data width
ADDRESS_WIDTH, 32, PC and memory address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven on bubbles (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall_f  input  1  hazard unit: hold PC and decode register
flush_d  input  1  hazard unit: replace decode register contents with bubble
pcsrc_e  input  1  execute: taken branch/jump, redirect fetch
pctarget_e  input  ADDRESS_WIDTH  execute: redirect target
imem_req  output  1  fetch request valid
imem_addr  output  ADDRESS_WIDTH  fetch address (equals pcf)
imem_ready  input  1  memory: imem_rdata valid, request accepted this cycle
imem_rdata  input  DATA_WIDTH  fetched instruction
instrd  output  DATA_WIDTH  instruction to decode
pcd  output  ADDRESS_WIDTH  PC of instrd
pcplus4d  output  ADDRESS_WIDTH  pcd+4
validd  output  1  instrd is a real instruction
fetch_busy  output  1  request outstanding without ready (debug/perf)

Behaviour:
- Reset (async, rst_n=0): pcf=RESET_PC, state=FETCH, redir_pend=0, buffer cleared, instrd=NOP_INSTR, pcd=0, pcplus4d=0, validd=0. imem_req=0 while rst_n=0; first request on first cycle after deassertion.
- States: FETCH (imem_req=1, imem_addr=pcf) and HELD (imem_req=0; instruction held in internal buffer with its PC).
- imem_addr must stay stable while imem_req=1 and imem_ready=0. Memory may respond in the request cycle (zero wait) or later.
- Accept = FETCH & imem_ready.
  - On accept with no redirect/pending: if !stall_f, deliver to decode and pcf<=pcf+4. If stall_f, copy rdata+pcf to buffer, pcf<=pcf+4, go HELD.
  - In HELD with !stall_f: deliver buffer to decode, go FETCH.
- Redirect (pcsrc_e=1) overrides stall_f.
  - FETCH with accept same cycle: discard response, pcf<=pctarget_e.
  - FETCH without ready: latch target, redir_pend=1, keep imem_addr. A later pcsrc_e before ready overwrites the latched target. When ready arrives, discard the response, pcf<=latched target, redir_pend=0.
  - HELD: discard buffer, pcf<=pctarget_e, go FETCH.
  - Discarded responses never reach decode.
- Decode register priority per cycle: flush_d, then stall_f, then deliver, then bubble.
  - flush_d: NOP_INSTR, validd=0, pcd=0, pcplus4d=0.
  - stall_f: hold all outputs.
  - deliver: instrd=instruction, pcd=its PC, pcplus4d=PC+4, validd=1.
  - bubble: no deliverable instruction; NOP_INSTR, validd=0, pcd/pcplus4d hold.
- flush_d and stall_f together: flush wins; a delivered or held instruction is still not lost (it stays in, or goes to, the buffer).
- Arithmetic: PC+4 modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC wraps to 0. pctarget_e is used unmodified; alignment is the execute stage's job.
- fetch_busy = FETCH & imem_req & !imem_ready.
- Reset mid-request: abandon the transaction; the late imem_ready after reset is ignored because imem_req=0 in the first post-reset cycle.

Test Plan:
- Reset, zero-wait memory returning addr-derived words: imem_addr 0,4,8 on successive cycles. validd=1 from second cycle. pcd=0 with instrd=mem[0], pcplus4d=4.
- Memory with 2 wait states at pc=8: imem_addr held at 8 for 3 cycles, fetch_busy=1 for 2 cycles. Decode gets bubbles (validd=0) then pcd=8.
- stall_f high 3 cycles during accept of pc=12: state HELD, imem_req=0, decode outputs frozen. On release, pcd=12 delivered and next request is 16.
- pcsrc_e with pctarget_e=0x100 during a 2-wait request at 0x20: response for 0x20 dropped (never validd=1 with pcd=0x20). Next imem_addr=0x100.
- flush_d with stall_f while HELD holds pc=0x40: instrd=NOP_INSTR, validd=0. After release, pcd=0x40 delivered, no instruction lost.
- Force pcf=32'hFFFF_FFFC via redirect: next imem_addr=0. pcplus4d for that instruction=0.
